// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared definitions for the gate truth-table checker.
//   state_e  - checker FSM states (IDLE=0, DRIVE=1, WAIT=2, SAMPLE=3, DONE=4)
//   TT_*     - 2-input truth tables, bit v = gate output for input vector v
//   tt_of    - truth table lookup by gate kind
package gate_tt_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        G_AND2,
        G_OR2,
        G_XOR2,
        G_NAND2
    } gate_e;

    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

    function automatic logic [3:0] tt_of(input gate_e g);
        return g == G_AND2 ? TT_AND2 :
               g == G_OR2  ? TT_OR2  :
               g == G_XOR2 ? TT_XOR2 : TT_NAND2;
    endfunction

endpackage

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: drives every input vector into a combinational gate, samples
// its output after a settle delay and compares it with an expected truth table.
//   clk, rst   clock and synchronous active-high reset
//   start      run request, accepted only in IDLE
//   dut_in     vector driven to the gate inputs (bit 0 = first input)
//   dut_out    gate output under test
//   busy       run in progress (through the done cycle)
//   done       one-cycle pulse at end of run
//   pass       last completed run had zero mismatches
//   err_count  mismatching vectors in current/last run
//   fail_vec   bit v set = vector v mismatched
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = TT_AND2,
    parameter int                 SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [2**N_IN-1:0]   fail_vec
);

    localparam int            NV   = 2**N_IN;
    // One bit wider than the vector so the last-vector compare never wraps.
    localparam logic [N_IN:0] LAST = (N_IN+1)'(NV-1);

    state_e            state_q, state_d;
    logic [N_IN:0]     vec_q, vec_d;
    logic [3:0]        settle_q, settle_d;
    logic [N_IN-1:0]   din_q, din_d;
    logic              busy_q, busy_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_q, err_d;
    logic [NV-1:0]     fail_q, fail_d;
    logic [N_IN-1:0]   idx;
    logic              mismatch;

    assign idx      = vec_q[N_IN-1:0];
    // Case inequality so an undriven/unknown output counts as a mismatch.
    assign mismatch = dut_out !== EXP_TT[idx];

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        din_d    = din_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_DRIVE;
                vec_d   = '0;
                err_d   = '0;
                fail_d  = '0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
            end
            S_DRIVE: begin
                din_d    = idx;
                settle_d = 4'(SETTLE);
                state_d  = SETTLE == 0 ? S_SAMPLE : S_WAIT;
            end
            S_WAIT: begin
                settle_d = settle_q - 4'd1;
                state_d  = settle_q == 4'd1 ? S_SAMPLE : S_WAIT;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d       = err_q + (N_IN+1)'(1);
                    fail_d[idx] = 1'b1;
                end
                state_d = vec_q == LAST ? S_DONE : S_DRIVE;
                vec_d   = vec_q == LAST ? vec_q : vec_q + (N_IN+1)'(1);
            end
            S_DONE: begin
                pass_d  = err_q == '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign dut_in    = din_q;
    assign busy      = busy_q;
    assign done      = state_q == S_DONE;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
